// File: rtl/line_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// line_buffer_ctrl
//   Sequencer for the 5-row line buffer in the LeNet conv front end. Takes a
//   raw pixel stream, drives the line buffer's shift enable / data / mode,
//   tracks row and col within a square frame, and flags when the five line
//   outputs hold a complete KxK window for the conv5x5 MAC array.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. A valid window (win_valid) is held with stable win_row/win_col
//   until a cycle with m_ready=1; the upstream source may hold s_data while
//   s_ready=0 and the pixel is taken only on s_valid & s_ready.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start, cfg_mode  frame start pulse and mode (0:W=28 1:W=14 2:W=10)
//   s_valid/s_ready/s_data     upstream pixel stream
//   lb_mode, lb_shift_en, lb_data   line buffer control
//   win_valid, win_row, win_col, m_ready   window handshake to MAC array
//   busy, frame_done, cfg_err  status
//   stall_cnt        (only with LB_CTRL_PERF_EN) window stall cycle counter
//
// Build option
//   LB_CTRL_PERF_EN  adds stall_cnt[31:0]
// ---------------------------------------------------------------------------
module line_buffer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_WIDTH  = 28,
  parameter int K          = 5,
  localparam int CW        = $clog2(MAX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            cfg_mode,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [2:0]            lb_mode,
  output logic                  lb_shift_en,
  output logic [DATA_WIDTH-1:0] lb_data,
  output logic                  win_valid,
  output logic [CW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  cfg_err
`ifdef LB_CTRL_PERF_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] KM2 = CW'(K - 2);

  state_t        state;
  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] w_last;     // W-1 of the latched mode
  logic [CW-1:0] row_nxt;
  logic [CW-1:0] col_nxt;
  logic [CW-1:0] mode_w_last;
  logic          mode_ok;
  logic          accept;
  logic          col_last;
  logic          qualify;

  // Mode decode: W-1 for each legal mode; modes 3..7 are reserved.
  always_comb begin
    mode_ok     = 1'b1;
    mode_w_last = CW'(27);
    case (cfg_mode)
      3'd0:    mode_w_last = CW'(27);
      3'd1:    mode_w_last = CW'(13);
      3'd2:    mode_w_last = CW'(9);
      default: mode_ok     = 1'b0;
    endcase
  end

  // Upstream ready. While a window is waiting on the MAC array we must not
  // shift the line buffer, otherwise the held window would be overwritten.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      FILL:    s_ready = 1'b1;
      STREAM:  s_ready = ~(win_valid & ~m_ready);
      default: s_ready = 1'b0;
    endcase
  end

  assign accept      = s_valid & s_ready;
  assign lb_shift_en = accept;
  assign lb_data     = s_data;
  assign busy        = (state != IDLE);

  assign col_last = (col == w_last);
  // An accepted pixel at or beyond (K-1, K-1) completes a window.
  assign qualify  = accept && (row >= KM1) && (col >= KM1);

  always_comb begin
    col_nxt = col + 1'b1;
    row_nxt = row;
    if (col_last) begin
      col_nxt = '0;
      row_nxt = row + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      w_last     <= '0;
      lb_mode    <= 3'd0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (mode_ok) begin
              lb_mode <= cfg_mode;
              w_last  <= mode_w_last;
              row     <= '0;
              col     <= '0;
              state   <= FILL;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        FILL: begin
          if (accept) begin
            row <= row_nxt;
            col <= col_nxt;
            // Wrapping out of row K-2 means the next pixel lands in row K-1.
            if (col_last && (row == KM2)) state <= STREAM;
          end
        end

        STREAM: begin
          if (accept) begin
            row <= row_nxt;
            col <= col_nxt;
          end
          if (qualify) begin
            win_valid <= 1'b1;
            win_row   <= row - KM1;
            win_col   <= col - KM1;
          end else if (m_ready) begin
            win_valid <= 1'b0;
          end
          if (accept && col_last && (row == w_last)) state <= DRAIN;
        end

        DRAIN: begin
          // The last pixel always produces a window; finish on its handshake.
          if (win_valid && m_ready) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef LB_CTRL_PERF_EN
  // Cycles a window waited on the MAC array. win_valid is never set in IDLE,
  // so the counter naturally freezes between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= '0;
    end else if (win_valid && !m_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
